inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch controller for the RV32I core. It owns the fetch PC, drives the word address into the combinational instruction ROM and captures the returned word with its PC into a 2-entry prefetch buffer. It delivers instructions to decode over a valid/ready handshake and handles branch/jump redirects from execute, with buffer flush, and a fetch halt. It sits between the instruction ROM and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be word aligned
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, synchronous, active-high
- oRomAddr  out  32  byte address to ROM read port; ROM indexes with [31:2]
- iRomData  in  32  ROM read data, combinational from oRomAddr
- oInstValid  out  1  buffer head holds a valid instruction
- oInst  out  32  head instruction word
- oInstPc  out  32  PC of head instruction
- iInstReady  in  1  decode accepts head this cycle
- iRedirect  in  1  taken branch/jump; single-cycle pulse
- iRedirectPc  in  32  redirect target
- iHalt  in  1  suppress new fetches while high; buffer still drains
- oBufLevel  out  2  buffer occupancy, 0..2
- oMisalign  out  1  misaligned-redirect trap flag (MISALIGN_TRAP_EN only; tied 0 otherwise)
- Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- State machine RUN / HOLD / TRAP. Reset enters RUN.
- RUN → HOLD when iHalt=1. HOLD → RUN when iHalt=0. Any state → TRAP on a misaligned redirect (macro only). TRAP exits only on reset or an aligned redirect, which goes to RUN, or to HOLD if iHalt=1.
- oRomAddr = rFetchPc at all times, registered source.
- pop = oInstValid & iInstReady.
- push = (state==RUN) & !iRedirect & (level<2 | pop).
- On push: write {rFetchPc, iRomData} to the tail, and rFetchPc += 4 with modulo-2^32 wrap. No ROM-range check: the address wraps as the ROM indexes it.
- Push and pop in the same cycle: level unchanged. Push with a full buffer is legal only if pop is also asserted.
- Redirect, highest priority: flush the buffer (level := 0) and set rFetchPc := iRedirectPc. No push that cycle; the word fetched that cycle is discarded. A pop in the redirect cycle counts as consumed by decode.
- Outputs when empty: oInstValid=0, oInst=0, oInstPc=0.
- Head outputs come straight from the head register. No combinational path from iRomData or iInstReady to oInst or oInstValid.

## Timing
- Reset values: rFetchPc=RESET_PC, oRomAddr=RESET_PC, oInstValid=0, oInst=0, oInstPc=0, oBufLevel=0, oMisalign=0, state RUN.
- First edge with iRst=0 pushes the word at RESET_PC. oInstValid=1 after that edge.
- Fetch latency: 1 cycle, PC to oInstValid.
- Throughput: 1 instruction/cycle with iInstReady held high.
- Back-pressure: with iInstReady=0 the buffer fills in 2 cycles. After that, rFetchPc and oRomAddr hold. The first cycle iInstReady=1 pops one and pushes one.
- Redirect penalty: redirect at edge N; target is on oRomAddr after N and pushed at N+1. oInstValid=1 with oInstPc=target after N+1.
- iHalt sampled each edge. Asserting it stops pushes from that edge on; deasserting it resumes pushes at the next edge.
- Reset mid-operation overrides everything: buffer emptied and PC reloaded at that edge.

## Configuration
- MISALIGN_TRAP_EN defined: a redirect with iRedirectPc[1:0]≠0 flushes the buffer, loads rFetchPc with the raw target, enters TRAP, and sets oMisalign=1 after that edge. No fetches occur in TRAP. oMisalign clears on reset or on an aligned redirect.
- MISALIGN_TRAP_EN undefined: rFetchPc := {iRedirectPc[31:2],2'b00}. No TRAP state exists and oMisalign is tied 0.

## Test plan
- Reset then free-run: ROM words 0..3 = A,B,C,D, iInstReady=1 → oInst A,B,C,D on consecutive cycles, oInstPc 0,4,8,12.
- Back-pressure: iInstReady=0 for 4 cycles after reset → oBufLevel 1 then 2, oRomAddr stuck at 8, oInst=A held. Ready released → A,B,C in order with no gap or duplicate.
- Redirect with a full buffer: level 2, iRedirect=1, iRedirectPc=0x48 → next cycle oInstValid=0, oBufLevel=0, oRomAddr=0x48. Following cycle oInstPc=0x48, oInst=ROM[18].
- Halt: iHalt=1 with level 2 and ready=1 → drains to 0 in 2 cycles, oRomAddr constant. iHalt=0 → resumes at the held PC.
- Simultaneous pop+redirect and reset-mid-stream: popped head not re-delivered and target delivered next. iRst pulse with level 2 → all outputs at reset values, then restart at RESET_PC.
- Misaligned redirect to 0x4A: with MISALIGN_TRAP_EN, oMisalign=1, no valid, and aligned redirect to 0x10 clears it and delivers ROM[4]. Without MISALIGN_TRAP_EN, oInstPc=0x48.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: fetch PC, ROM address, 2-entry prefetch buffer, redirect/halt.
// Optional MISALIGN_TRAP_EN: misaligned redirects trap instead of being force-aligned.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic [31:0] oRomAddr,
    input  logic [31:0] iRomData,
    output logic        oInstValid,
    output logic [31:0] oInst,
    output logic [31:0] oInstPc,
    input  logic        iInstReady,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    input  logic        iHalt,
    output logic [1:0]  oBufLevel,
    output logic        oMisalign
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LVL_W = 2;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_TRAP} state_t;
`else
    typedef enum logic [0:0] {ST_RUN, ST_HOLD} state_t;
`endif

    state_t             state_q, state_d;
    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [XLEN-1:0]    pc0_q, pc0_d, inst0_q, inst0_d;
    logic [XLEN-1:0]    pc1_q, pc1_d, inst1_q, inst1_d;
    logic               misalign_q, misalign_d;
    logic               pop_c, push_c, misaligned_c;

    // Next state, fetch PC and buffer update
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        level_d      = level_q;
        pc0_d        = pc0_q;
        inst0_d      = inst0_q;
        pc1_d        = pc1_q;
        inst1_d      = inst1_q;
        misalign_d   = misalign_q;
        misaligned_c = 1'b0;

        case (state_q)
            ST_RUN:  if (iHalt)  state_d = ST_HOLD;
            ST_HOLD: if (!iHalt) state_d = ST_RUN;
            default: state_d = state_q;
        endcase

`ifdef MISALIGN_TRAP_EN
        misaligned_c = iRedirect && (iRedirectPc[1:0] != 2'b00);
        if (iRedirect) begin
            if (misaligned_c)
                state_d = ST_TRAP;
            else if (state_q == ST_TRAP)
                state_d = iHalt ? ST_HOLD : ST_RUN;
        end
`endif

        // Halt is qualified through the next state so pushes stop on the edge that samples it
        pop_c  = (level_q != LVL_W'(0)) && iInstReady;
        push_c = (state_d == ST_RUN) && !iRedirect && ((level_q != LVL_W'(2)) || pop_c);

        if (iRedirect) begin
            level_d    = LVL_W'(0);
            pc0_d      = '0;
            inst0_d    = '0;
            pc1_d      = '0;
            inst1_d    = '0;
            misalign_d = misaligned_c;
`ifdef MISALIGN_TRAP_EN
            fetch_pc_d = iRedirectPc;
`else
            fetch_pc_d = iRedirectPc & ~XLEN'(3);
`endif
        end else begin
            if (push_c)
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            case ({push_c, pop_c})
                2'b11: begin
                    if (level_q == LVL_W'(1)) begin
                        pc0_d   = fetch_pc_q;
                        inst0_d = iRomData;
                    end else begin
                        pc0_d   = pc1_q;
                        inst0_d = inst1_q;
                        pc1_d   = fetch_pc_q;
                        inst1_d = iRomData;
                    end
                end
                2'b01: begin
                    if (level_q == LVL_W'(1)) begin
                        pc0_d   = '0;
                        inst0_d = '0;
                        level_d = LVL_W'(0);
                    end else begin
                        pc0_d   = pc1_q;
                        inst0_d = inst1_q;
                        pc1_d   = '0;
                        inst1_d = '0;
                        level_d = LVL_W'(1);
                    end
                end
                2'b10: begin
                    if (level_q == LVL_W'(0)) begin
                        pc0_d   = fetch_pc_q;
                        inst0_d = iRomData;
                        level_d = LVL_W'(1);
                    end else begin
                        pc1_d   = fetch_pc_q;
                        inst1_d = iRomData;
                        level_d = LVL_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            level_q    <= '0;
            pc0_q      <= '0;
            inst0_q    <= '0;
            pc1_q      <= '0;
            inst1_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            level_q    <= level_d;
            pc0_q      <= pc0_d;
            inst0_q    <= inst0_d;
            pc1_q      <= pc1_d;
            inst1_q    <= inst1_d;
            misalign_q <= misalign_d;
        end
    end

    assign oRomAddr   = fetch_pc_q;
    assign oInstValid = (level_q != LVL_W'(0));
    assign oInst      = inst0_q;
    assign oInstPc    = pc0_q;
    assign oBufLevel  = level_q;
`ifdef MISALIGN_TRAP_EN
    assign oMisalign  = misalign_q;
`else
    assign oMisalign  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: scoreboard of expected deliveries plus direct output checks.
module tb_inst_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [1:0]  buf_level;
    logic        misalign;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA5A5_0000 + {2'b00, a[31:2]} * 32'h0001_0003;
    endfunction

    assign rom_data = rom_word(rom_addr);

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .oRomAddr    (rom_addr),
        .iRomData    (rom_data),
        .oInstValid  (inst_valid),
        .oInst       (inst),
        .oInstPc     (inst_pc),
        .iInstReady  (inst_ready),
        .iRedirect   (redirect),
        .iRedirectPc (redirect_pc),
        .iHalt       (halt),
        .oBufLevel   (buf_level),
        .oMisalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] a);
        exp_q.push_back({a, rom_word(a)});
    endtask

    // One cycle: score any handshake with stable inputs, then settle just after the edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed pc %h expected no delivery", inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_inst", inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_romaddr"}, rom_addr, 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_pc"}, inst_pc, 32'h0);
        chk({tag, "_level"}, 32'(buf_level), 32'h0);
        chk({tag, "_misalign"}, 32'(misalign), 32'h0);
    endtask

    initial begin
        rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        step();
        step();
        chk_reset("rst0");

        // Free run
        rst = 1'b0; inst_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        step();
        chk("fr_valid", 32'(inst_valid), 32'h1);
        chk("fr_pc0", inst_pc, 32'h0);
        chk("fr_romaddr", rom_addr, 32'h4);
        step(); step(); step(); step();
        inst_ready = 1'b0; rst = 1'b1;
        step();
        chk_reset("rst1");

        // Back-pressure
        rst = 1'b0;
        step();
        chk("bp_level1", 32'(buf_level), 32'h1);
        step();
        chk("bp_level2", 32'(buf_level), 32'h2);
        chk("bp_romaddr2", rom_addr, 32'h8);
        step(); step();
        chk("bp_romaddr4", rom_addr, 32'h8);
        chk("bp_inst_held", inst, rom_word(32'h0));
        chk("bp_level4", 32'(buf_level), 32'h2);
        inst_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        step(); step(); step();
        inst_ready = 1'b0;
        chk("bp_end_level", 32'(buf_level), 32'h2);
        chk("bp_end_pc", inst_pc, 32'hC);

        // Redirect with a full buffer
        redirect = 1'b1; redirect_pc = 32'h48;
        step();
        chk("rd_valid", 32'(inst_valid), 32'h0);
        chk("rd_level", 32'(buf_level), 32'h0);
        chk("rd_romaddr", rom_addr, 32'h48);
        chk("rd_inst0", inst, 32'h0);
        redirect = 1'b0; inst_ready = 1'b1;
        expect_pc(32'h48); expect_pc(32'h4C);
        step();
        chk("rd_tgt_valid", 32'(inst_valid), 32'h1);
        chk("rd_tgt_pc", inst_pc, 32'h48);
        chk("rd_tgt_inst", inst, rom_word(32'h48));
        step();

        // Pop in the redirect cycle
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("pr_valid", 32'(inst_valid), 32'h0);
        expect_pc(32'h100);
        step();
        chk("pr_tgt_pc", inst_pc, 32'h100);
        step();
        inst_ready = 1'b0;
        step();
        chk("ht_pre_level", 32'(buf_level), 32'h2);
        chk("ht_pre_romaddr", rom_addr, 32'h10C);

        // Halt drains the buffer, PC holds
        halt = 1'b1; inst_ready = 1'b1;
        expect_pc(32'h104); expect_pc(32'h108);
        step();
        chk("ht_level1", 32'(buf_level), 32'h1);
        chk("ht_romaddr1", rom_addr, 32'h10C);
        step();
        chk("ht_level0", 32'(buf_level), 32'h0);
        chk("ht_valid0", 32'(inst_valid), 32'h0);
        step();
        chk("ht_romaddr_hold", rom_addr, 32'h10C);
        halt = 1'b0;
        step();
        chk("ht_resume_pc", inst_pc, 32'h10C);
        chk("ht_resume_level", 32'(buf_level), 32'h1);
        inst_ready = 1'b0;
        step();
        chk("ms_full_level", 32'(buf_level), 32'h2);

        // Reset mid-stream with a full buffer
        rst = 1'b1;
        step();
        chk_reset("rst2");
        rst = 1'b0;
        step();
        chk("rs_restart_pc", inst_pc, 32'h0);
        chk("rs_restart_inst", inst, rom_word(32'h0));

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h4A;
        step();
        redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("ma_flag", 32'(misalign), 32'h1);
        chk("ma_valid", 32'(inst_valid), 32'h0);
        chk("ma_romaddr", rom_addr, 32'h4A);
        step();
        chk("ma_trap_valid", 32'(inst_valid), 32'h0);
        chk("ma_trap_level", 32'(buf_level), 32'h0);
        chk("ma_trap_romaddr", rom_addr, 32'h4A);
        chk("ma_trap_flag", 32'(misalign), 32'h1);
`else
        chk("ma_romaddr", rom_addr, 32'h48);
        chk("ma_flag", 32'(misalign), 32'h0);
        step();
        chk("ma_pc", inst_pc, 32'h48);
        chk("ma_inst", inst, rom_word(32'h48));
`endif
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        chk("al_flag", 32'(misalign), 32'h0);
        chk("al_romaddr", rom_addr, 32'h10);
        inst_ready = 1'b1;
        expect_pc(32'h10); expect_pc(32'h14);
        step();
        chk("al_pc", inst_pc, 32'h10);
        chk("al_inst", inst, rom_word(32'h10));
        step();
        step();
        inst_ready = 1'b0;

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
